// File: rtl/gray_binary_decoder.sv
// Streaming Gray-to-binary decoder with single-step checking.
//
// Accepts Gray-coded samples on a valid/ready input, decodes them to binary
// through a two-stage pipeline and tags each sample with:
//   - first    : no predecessor (first after reset or hist_clr)
//   - step_err : sample differed from its predecessor in 0 or >= 2 bits
//   - dir      : 01 = +1 step, 10 = -1 step, 00 = first or error
// A saturating counter tracks how many step-error samples left the block.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_gray valid
//   in_ready     decoder can accept this cycle
//   in_gray      Gray-coded sample
//   hist_clr     forget previous-code history
//   out_valid    out_* fields valid
//   out_ready    downstream accepts this cycle
//   out_bin      decoded binary value
//   out_first    sample had no predecessor
//   out_step_err sample was not a single-bit step
//   out_dir      count direction
//   err_cnt      saturating count of step errors transferred on the output

module gray_binary_decoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    input  logic             hist_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_first,
    output logic             out_step_err,
    output logic [1:0]       out_dir,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] DirNone = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDown = 2'b10;

    // Prefix XOR from the MSB down.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // ------------------------------------------------------------------
    // Handshake / pipeline enables
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic en1, en2;
    logic in_xfer, out_xfer;

    always_comb begin
        en2      = ~v2_q | out_ready;
        en1      = ~v1_q | en2;
        in_ready = en1;
        in_xfer  = in_valid & en1;
        out_xfer = v2_q & out_ready;
    end

    // ------------------------------------------------------------------
    // Stage 1: capture sample and check step against history
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             hist_valid_q, hist_valid_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    // Predecessor code travels with the sample so stage 2 can decode prev_bin
    // without depending on later history updates.
    logic [WIDTH-1:0] pg1_q, pg1_d;
    logic             first1_q, first1_d;
    logic             err1_q, err1_d;

    logic             hv_eff;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // A clear applies before the check of a sample accepted in the same cycle.
        hv_eff       = hist_valid_q & ~hist_clr;
        diff         = in_gray ^ prev_gray_q;

        prev_gray_d  = prev_gray_q;
        hist_valid_d = hv_eff;
        g1_d         = g1_q;
        pg1_d        = pg1_q;
        first1_d     = first1_q;
        err1_d       = err1_q;
        v1_d         = v1_q;

        if (in_xfer) begin
            g1_d         = in_gray;
            pg1_d        = prev_gray_q;
            first1_d     = ~hv_eff;
            err1_d       = hv_eff & ~is_one_hot(diff);
            prev_gray_d  = in_gray;
            hist_valid_d = 1'b1;
            v1_d         = 1'b1;
        end else if (en1) begin
            v1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q  <= '0;
            hist_valid_q <= 1'b0;
            g1_q         <= '0;
            pg1_q        <= '0;
            first1_q     <= 1'b0;
            err1_q       <= 1'b0;
            v1_q         <= 1'b0;
        end else begin
            prev_gray_q  <= prev_gray_d;
            hist_valid_q <= hist_valid_d;
            g1_q         <= g1_d;
            pg1_q        <= pg1_d;
            first1_q     <= first1_d;
            err1_q       <= err1_d;
            v1_q         <= v1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: decode to binary and classify direction
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             first2_q, first2_d;
    logic             err2_q, err2_d;
    logic [1:0]       dir_q, dir_d;

    logic [WIDTH-1:0] bin_s1;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;
    logic [1:0]       dir_s1;

    always_comb begin
        bin_s1   = gray_to_bin(g1_q);
        prev_bin = gray_to_bin(pg1_q);
        // Modular arithmetic gives the all-ones <-> zero wrap for free.
        prev_inc = prev_bin + WIDTH'(1);
        prev_dec = prev_bin - WIDTH'(1);

        dir_s1 = DirNone;
        if (!first1_q && !err1_q) begin
            if (bin_s1 == prev_inc) begin
                dir_s1 = DirUp;
            end else if (bin_s1 == prev_dec) begin
                dir_s1 = DirDown;
            end
        end

        bin_d    = bin_q;
        first2_d = first2_q;
        err2_d   = err2_q;
        dir_d    = dir_q;
        v2_d     = v2_q;

        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                bin_d    = bin_s1;
                first2_d = first1_q;
                err2_d   = err1_q;
                dir_d    = dir_s1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            first2_q <= 1'b0;
            err2_q   <= 1'b0;
            dir_q    <= DirNone;
            v2_q     <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            first2_q <= first2_d;
            err2_q   <= err2_d;
            dir_q    <= dir_d;
            v2_q     <= v2_d;
        end
    end

    // ------------------------------------------------------------------
    // Step-error counter: counts errors as they leave, saturating
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_xfer && err2_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid    = v2_q;
        out_bin      = bin_q;
        out_first    = first2_q;
        out_step_err = err2_q;
        out_dir      = dir_q;
        err_cnt      = err_cnt_q;
    end

endmodule

// File: doc/gray_binary_decoder.md
Name: gray_binary_decoder

Overview:
- Streaming Gray-to-binary decoder: the receive-side counterpart of the team's binary_gray converter.
- Accepts Gray-coded samples over a valid/ready interface and outputs the binary value through a 2-stage pipeline.
- Checks that each accepted code differs from the previous one by exactly one bit, and reports the count direction.
- Sits downstream of Gray-coded position counters and pointer paths; feeds binary consumers and error monitoring.

Parameters:
- WIDTH, 4, code width in bits (>= 2)
- CNT_W, 8, width of saturating step-error counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_gray valid
- in_ready  output  1  decoder can accept this cycle
- in_gray  input  WIDTH  Gray-coded sample
- hist_clr  input  1  forget previous-code history; next accepted sample is treated as first
- out_valid  output  1  out_* fields valid
- out_ready  input  1  downstream accepts this cycle
- out_bin  output  WIDTH  decoded binary value
- out_first  output  1  sample had no predecessor (first after reset or hist_clr)
- out_step_err  output  1  sample differed from predecessor in 0 or >=2 bits
- out_dir  output  2  01 = +1 step, 10 = -1 step, 00 = first or error
- err_cnt  output  CNT_W  saturating count of step errors

Behaviour:
- Reset (async assert, sync deassert by the source):
  - all valid flags, out_bin, out_first, out_step_err, out_dir, err_cnt and history go to 0.
  - hist_valid = 0.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_* stay stable while out_valid & !out_ready.
- Pipeline enables (combinational ready path, no bubbles at full throughput):
  - en2 = !v2 | out_ready
  - en1 = !v1 | en2
  - in_ready = en1
- Stage 1 (on input transfer):
  - Register in_gray.
  - Compute diff = in_gray ^ prev_gray.
  - first = !hist_valid.
  - err = hist_valid & (popcount(diff) != 1).
  - Update prev_gray <= in_gray and hist_valid <= 1.
  - v1 <= 1; if en1 and no input transfer, v1 <= 0.
- Stage 2 (on en2 & v1):
  - Compute bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] ^ g[i].
  - Register bin, first and err.
  - dir:
    - 01 if !first & !err & (bin == prev_bin + 1 mod 2^WIDTH)
    - 10 if (bin == prev_bin - 1 mod 2^WIDTH)
    - otherwise 00
  - prev_bin is the binary of the predecessor and is kept alongside prev_gray.
  - v2 <= 1; if en2 and !v1, v2 <= 0.
- Latency and throughput: 2 cycles from input transfer to out_valid when unstalled; 1 sample per cycle sustained.
- Wrap-around: all-ones-binary to 0 (Gray 1000 -> 0000 at WIDTH=4) is a legal +1 step; the reverse is -1.
- Repeated identical code: popcount 0, so step error; dir 00.
- err_cnt:
  - Increments by 1 when an out_step_err sample transfers on the output.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- hist_clr:
  - Sets hist_valid <= 0 this cycle.
  - If asserted with an input transfer, the incoming sample is tagged first and history reloads from it (clear applies before the check).
  - Samples already in the pipeline are unaffected.
- Reset mid-operation: in-flight samples are discarded; no output transfer occurs until new input arrives.

Test Plan:
- WIDTH=4, out_ready=1, feed Gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 → out_bin 0..15 each 2 cycles after input, first=1 only on sample 0, dir=01 otherwise, err_cnt=0.
- Continue with 1000 → 0000, then 0000 → 1000 → wrap sample dir=01; next dir=10; no errors.
- Feed 0001 then 0001 then 0111 → second sample out_step_err=1 (0 bits changed), third out_step_err=1 (2 bits changed), dir=00 for both, err_cnt=2.
- Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready drops after 2 samples are held, out_bin stable, no sample lost or duplicated after release.
- Assert hist_clr with sample 1111 after stream ...0010 → sample 1111 out_first=1, out_step_err=0, bin=1010, dir=00.
- Drop rst_n while 2 samples are in flight → out_valid=0 and err_cnt=0 immediately (async); next sample after release is out_first=1.
